// File: rtl/ap_com_cfg_array.sv
`default_nettype none
// ============================================================================
// Module   : ap_com_cfg_array
// Purpose  : Runtime-programmable array of NUM_CELLS approximate compressor
//            cells. Each cell is a LUT_IN-input, 1-output lookup whose truth
//            table is written over a config port. Data flows through a
//            2-stage valid/ready pipeline; table writes are serialised
//            against data traffic so every output vector is evaluated with
//            one consistent table set.
// Ports    : clk, rst_n               - clock / async active-low reset
//            cfg_valid/ready/idx/table - single-cycle table write request
//            cfg_err                   - sticky out-of-range index flag
//            in_valid/ready/data       - input address vectors
//            out_valid/ready/data      - evaluated cell outputs
//            busy                      - controller not idle
// Revision : 1.0 - initial release
// ============================================================================
module ap_com_cfg_array #(
    parameter  int NUM_CELLS = 25,
    parameter  int LUT_IN    = 4,
    parameter  int IDX_W     = 5,
    localparam int TBL_W     = 1 << LUT_IN
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          cfg_valid,
    output logic                          cfg_ready,
    input  logic [IDX_W-1:0]              cfg_idx,
    input  logic [TBL_W-1:0]              cfg_table,
    output logic                          cfg_err,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [NUM_CELLS*LUT_IN-1:0]   in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [NUM_CELLS-1:0]          out_data,
    output logic                          busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_CFG  = 2'd2
    } state_t;

    state_t                        r_state;
    logic [IDX_W-1:0]              r_cfg_idx;
    logic [TBL_W-1:0]              r_cfg_tbl;
    logic                          r_cfg_err;
    logic [TBL_W-1:0]              r_tables [NUM_CELLS];

    logic                          r_s1_valid;
    logic [NUM_CELLS*LUT_IN-1:0]   r_s1_data;
    logic                          r_s2_valid;
    logic [NUM_CELLS-1:0]          r_s2_data;

    logic                          w_s2_free;
    logic                          w_s1_free;
    logic                          w_in_fire;
    logic                          w_idx_hit;
    logic [NUM_CELLS-1:0]          w_eval;

    // Stage 2 can take new content when empty or being drained this cycle;
    // stage 1 can take new content when empty or moving into stage 2.
    assign w_s2_free = !r_s2_valid || out_ready;
    assign w_s1_free = !r_s1_valid || w_s2_free;

    // A raised cfg_valid blocks new inputs (in IDLE it wins the arbitration,
    // in RUN it lets the pipeline drain so the write can start).
    assign in_ready  = (r_state != ST_CFG) && !cfg_valid && w_s1_free;
    assign cfg_ready = (r_state == ST_IDLE);
    assign w_in_fire = in_valid && in_ready;

    assign out_valid = r_s2_valid;
    assign out_data  = r_s2_data;
    assign cfg_err   = r_cfg_err;
    assign busy      = (r_state != ST_IDLE);

    // Captured index within the implemented cell range?
    always_comb begin
        w_idx_hit = 1'b0;
        for (int i = 0; i < NUM_CELLS; i++) begin
            if (r_cfg_idx == IDX_W'(i)) begin
                w_idx_hit = 1'b1;
            end
        end
    end

    // Per-cell table lookup on the stage-1 address
    for (genvar g = 0; g < NUM_CELLS; g++) begin : g_cell
        assign w_eval[g] = r_tables[g][r_s1_data[g*LUT_IN +: LUT_IN]];
    end

    // ------------------------------------------------------------------
    // Controller and table storage
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_cfg_idx <= '0;
            r_cfg_tbl <= '0;
            r_cfg_err <= 1'b0;
            for (int i = 0; i < NUM_CELLS; i++) begin
                r_tables[i] <= '0;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (cfg_valid) begin
                        // Request contents are frozen here; later changes on
                        // the config inputs are ignored.
                        r_cfg_idx <= cfg_idx;
                        r_cfg_tbl <= cfg_table;
                        r_state   <= ST_CFG;
                    end else if (w_in_fire) begin
                        r_state   <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (!r_s1_valid && !r_s2_valid && !w_in_fire) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_CFG: begin
                    // Pipeline is guaranteed empty here, so the write can
                    // never mix table sets within a vector.
                    for (int i = 0; i < NUM_CELLS; i++) begin
                        if (r_cfg_idx == IDX_W'(i)) begin
                            r_tables[i] <= r_cfg_tbl;
                        end
                    end
                    if (!w_idx_hit) begin
                        r_cfg_err <= 1'b1;
                    end
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Two-stage data pipeline
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= '0;
            r_s2_valid <= 1'b0;
            r_s2_data  <= '0;
        end else begin
            if (w_s1_free) begin
                r_s1_valid <= w_in_fire;
                if (w_in_fire) begin
                    r_s1_data <= in_data;
                end
            end
            // Data is only reloaded when a new vector arrives, so out_data
            // stays put both during a stall and after the stage empties.
            if (w_s2_free) begin
                r_s2_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_s2_data <= w_eval;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/ap_com_cfg_array.md
Name: ap_com_cfg_array

Overview:
- Runtime-programmable array of NUM_CELLS approximate compressor cells. Each cell is a LUT_IN-input, 1-output lookup whose truth table is loaded over a config port.
- The approximate-multiplier reduction tree uses it so that evolved compressor truth tables can be swapped without resynthesis.
- Data path: 2-stage pipeline with valid/ready handshakes on input and output.
- Config writes are serialised against data traffic by a small controller.

Parameters:
- NUM_CELLS, 25, number of compressor cells.
- LUT_IN, 4, inputs per cell; truth table width TBL_W = 2^LUT_IN.
- IDX_W, 5, width of cfg_idx; must satisfy 2^IDX_W >= NUM_CELLS.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cfg_valid  in  1  config write request.
- cfg_ready  out  1  config write accepted when high with cfg_valid.
- cfg_idx  in  IDX_W  target cell index.
- cfg_table  in  TBL_W  truth table; bit k = cell output for input address k.
- cfg_err  out  1  sticky flag: an out-of-range cfg_idx was accepted.
- in_valid  in  1  input vector valid.
- in_ready  out  1  input accepted when high with in_valid.
- in_data  in  NUM_CELLS*LUT_IN  cell i address = in_data[i*LUT_IN +: LUT_IN]; MSB is input a.
- out_valid  out  1  output vector valid.
- out_ready  in  1  downstream accepts output.
- out_data  out  NUM_CELLS  bit i = table_i[address_i].
- busy  out  1  pipeline holds data or a config write is in progress.

Behaviour:
- Reset (async assert, sync release):
  - All tables = 0; both pipeline stages invalid.
  - out_valid=0, out_data=0, cfg_err=0, busy=0.
  - Controller enters IDLE.
- Controller states:
  - IDLE: pipeline empty.
  - RUN: at least one stage valid.
  - CFG: single-cycle table write.
- cfg_ready: high only in IDLE. in_ready is low in CFG.
- IDLE transitions:
  - cfg_valid=1 → CFG. The config transfer takes priority: in_ready=0 in that cycle even if in_valid=1.
  - Otherwise in_valid=1 → RUN, and the input is accepted.
- CFG: on the next edge, if cfg_idx < NUM_CELLS then table[cfg_idx] <= cfg_table; otherwise there is no write and cfg_err <= 1. Then → IDLE.
- cfg_idx and cfg_table are captured at acceptance. Later changes have no effect.
- RUN: new inputs are accepted while the stall rule allows. Return to IDLE when both stages are empty and no input is accepted that cycle.
- cfg_valid asserted in RUN waits, with cfg_ready=0, until the pipeline drains. Once a config request is pending in RUN, in_ready=0, so the drain is guaranteed.
- Pipeline:
  - Stage 1 registers in_data.
  - Stage 2 registers the LUT evaluation of stage 1 using the current tables.
  - Latency: 2 cycles from input acceptance to out_valid with out_ready=1.
  - Throughput: 1 vector/cycle.
- Stall rule:
  - Stage 2 holds when out_valid=1 and out_ready=0.
  - Stage 1 advances only if stage 2 is empty or advancing.
  - in_ready = (stage 1 empty or advancing) and no config pending.
  - out_data is stable while out_valid=1 and out_ready=0.
- Tables never change while data is in flight, so outputs always reflect one consistent table set.
- A cell using fewer than LUT_IN inputs needs its unused input bits tied 0 by the instantiator. Only table entries reachable with those bits at 0 matter.
- busy = (state != IDLE).
- cfg_err clears only on reset.
- Reset mid-operation: in-flight vectors are discarded; all tables return to 0.

Test Plan:
- Reset, then drive in_valid with in_data all-ones → out_data=0 after 2 cycles (all tables zero); busy=1 during, 0 after drain.
- Write cell 0 with cfg_table=16'hBBB4, then send cell-0 addresses 0,2,4,6 on back-to-back cycles with out_ready=1 → out_data[0]=0,1,1,0 on consecutive cycles, starting 2 cycles after the first input.
- Write cfg_idx=30 (NUM_CELLS=25) → cfg_err=1 after the write cycle, no table modified; then write cell 24 with 16'hFFFF → out_data[24]=1 for any address, cfg_err remains 1.
- Stream 4 vectors and hold out_ready=0 for 3 cycles → out_data holds its first value, in_ready falls once both stages are full, no vector is lost or duplicated, and the order is preserved.
- Assert cfg_valid while 2 vectors are in flight → cfg_ready stays 0 and in_ready=0 until drain. Both vectors emerge evaluated with the old table, then the write completes and the next vector uses the new table.
- Pulse rst_n low asynchronously mid-stream → out_valid=0 immediately, tables=0, and state=IDLE after release.
